ibram_pingpong_scheduler: RTL

- Sequences ownership of the two halves (ping = 0, pong = 1) of the banked input-activation BRAM buffer.
- Arbitrates write access between iwrite controller 1 (initial loader) and iwrite controller 2 (steady-state streamer).
- Hands each filled half to the ibram read controller through a valid/ready descriptor, and returns the half to the writers once the reader signals completion.

---
 rtl/ibram_pingpong_scheduler_if.sv | 31 +++
 rtl/ibram_pingpong_scheduler.sv | 116 +++++++++++
 2 files changed

// File: rtl/ibram_pingpong_scheduler_if.sv
// Bundle between the ping-pong scheduler, the two iwrite controllers and the ibram read controller.
// Handshake: the reader takes a half when rd_valid && rd_ready on a rising edge; rd_valid is held until then.
interface ibram_pingpong_scheduler_if #(
  parameter int WR_LEN_W = 8,
  parameter int RD_LEN_W = 12
);
  logic [1:0]          wr_req;
  logic [1:0]          wr_gnt;
  logic                wr_half;
  logic                wr_done;
  logic [WR_LEN_W-1:0] wr_len;
  logic                rd_valid;
  logic                rd_half;
  logic [RD_LEN_W-1:0] rd_len;
  logic                rd_ready;
  logic                rd_done;
  logic [1:0]          half_full;
  logic                busy;
  logic                len_err;
  logic [0:0]          arb_state;

  modport master (
    input  wr_req, wr_done, wr_len, rd_ready, rd_done,
    output wr_gnt, wr_half, rd_valid, rd_half, rd_len, half_full, busy, len_err, arb_state
  );

  modport slave (
    output wr_req, wr_done, wr_len, rd_ready, rd_done,
    input  wr_gnt, wr_half, rd_valid, rd_half, rd_len, half_full, busy, len_err, arb_state
  );
endinterface

// File: rtl/ibram_pingpong_scheduler.sv
// Owns the ping/pong halves of the input-activation BRAM: arbitrates the two writers,
// offers filled halves to the reader in fill order and recycles them on rd_done.
module ibram_pingpong_scheduler #(
  parameter int WRITE_WIDTH = 128,
  parameter int WRITE_DEPTH = 128,
  parameter int READ_WIDTH  = 8,
  parameter int READ_DEPTH  = WRITE_WIDTH * WRITE_DEPTH / READ_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  ibram_pingpong_scheduler_if.master bus
);
  localparam int WL_W  = $clog2(WRITE_DEPTH) + 1;
  localparam int RL_W  = $clog2(READ_DEPTH) + 1;
  localparam int SHIFT = $clog2(WRITE_WIDTH / READ_WIDTH);
  localparam logic [WL_W-1:0] DEPTH_LEN = WL_W'(WRITE_DEPTH);

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_GRANT = 1'b1;

  localparam logic [1:0] H_EMPTY    = 2'd0;
  localparam logic [1:0] H_FILLING  = 2'd1;
  localparam logic [1:0] H_FULL     = 2'd2;
  localparam logic [1:0] H_DRAINING = 2'd3;

  logic [0:0]      arb_state;
  logic [1:0]      half_st [2];
  logic [WL_W-1:0] len_q [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic            last_gnt;
  logic [1:0]      gnt_q;
  logic            wr_half_q;
  logic            len_err_q;

  logic            rd_valid_c;
  logic            rd_take;
  logic            rd_free;
  logic            half_free;
  logic            win;
  logic [WL_W-1:0] wr_len_c;
  logic            len_over;

  always_comb begin
    rd_valid_c = (half_st[rd_ptr] == H_FULL);
    rd_take    = rd_valid_c && bus.rd_ready;
    rd_free    = bus.rd_done && (half_st[rd_ptr] == H_DRAINING);
    // A half released by the reader this cycle is already usable by the arbiter.
    half_free  = (half_st[wr_ptr] == H_EMPTY) || (rd_free && (rd_ptr == wr_ptr));
    win        = (&bus.wr_req) ? ~last_gnt : bus.wr_req[1];
    len_over   = (bus.wr_len > DEPTH_LEN);
    wr_len_c   = len_over ? DEPTH_LEN : bus.wr_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_state  <= ARB_IDLE;
      half_st[0] <= H_EMPTY;
      half_st[1] <= H_EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      last_gnt   <= 1'b1;
      gnt_q      <= 2'b00;
      wr_half_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      if (rd_take) half_st[rd_ptr] <= H_DRAINING;
      if (rd_free) begin
        half_st[rd_ptr] <= H_EMPTY;
        rd_ptr          <= ~rd_ptr;
      end
      // Writer-side updates come last so a grant on a just-freed half wins.
      case (arb_state)
        ARB_IDLE: begin
          if ((|bus.wr_req) && half_free) begin
            arb_state       <= ARB_GRANT;
            gnt_q           <= win ? 2'b10 : 2'b01;
            last_gnt        <= win;
            wr_half_q       <= wr_ptr;
            half_st[wr_ptr] <= H_FILLING;
          end
        end
        ARB_GRANT: begin
          if (bus.wr_done) begin
            arb_state <= ARB_IDLE;
            gnt_q     <= 2'b00;
            wr_half_q <= 1'b0;
            if (len_over) len_err_q <= 1'b1;
            if (bus.wr_len == '0) begin
              half_st[wr_ptr] <= H_EMPTY;
            end else begin
              half_st[wr_ptr] <= H_FULL;
              len_q[wr_ptr]   <= wr_len_c;
              wr_ptr          <= ~wr_ptr;
            end
          end
        end
        default: arb_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.wr_gnt    = gnt_q;
    bus.wr_half   = wr_half_q;
    bus.rd_valid  = rd_valid_c;
    bus.rd_half   = rd_ptr;
    bus.rd_len    = RL_W'(len_q[rd_ptr]) << SHIFT;
    bus.half_full = {half_st[1][1], half_st[0][1]};
    bus.busy      = (half_st[0] != H_EMPTY) || (half_st[1] != H_EMPTY) || (|gnt_q);
    bus.len_err   = len_err_q;
    bus.arb_state = arb_state;
  end
endmodule
